// File: rtl/alu_flag_branch_unit.sv
// alu_flag_branch_unit
//
// Consuming end of the ALU flag interface. The ALU drives its flags
// {odd_parity, positive, cout, zero} combinationally and holds nothing.
// This block holds those flags, feeds the carry back to the ALU, resolves
// conditional branches against them, and issues a one-cycle redirect/flush
// to fetch. A single-level shadow copy of the flags covers interrupt
// entry (save) and exit (restore).
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   flag_in        ALU flags {O, P, C, Z}, bit 3 down to bit 0
//   flag_we        load flag_in into the flag register
//   flag_busy      a flag-writing op is in flight upstream; hold branches
//   save           copy the current flags into the shadow register
//   restore        load the flags from the shadow register
//   br_valid       branch request present
//   br_cond        4-bit condition code
//   br_target      branch target PC
//   br_ready       request can be accepted this cycle (combinational)
//   redirect_valid one-cycle pulse: branch taken, flush younger stages
//   redirect_pc    target of the last taken branch
//   flags          current registered flags
//   cin_out        registered carry flag to the ALU carry input
//   taken_cnt      saturating count of taken branches

module alu_flag_branch_unit #(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       flag_in,
    input  logic             flag_we,
    input  logic             flag_busy,
    input  logic             save,
    input  logic             restore,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    input  logic [PC_W-1:0]  br_target,
    output logic             br_ready,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [3:0]       flags,
    output logic             cin_out,
    output logic [CNT_W-1:0] taken_cnt
);

    // Flag bit positions
    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_P = 2;
    localparam int unsigned FLG_O = 3;

    // Condition codes; 4'hC..4'hF are reserved and never taken
    localparam logic [3:0] CC_ALWAYS = 4'h0;
    localparam logic [3:0] CC_Z      = 4'h1;
    localparam logic [3:0] CC_NZ     = 4'h2;
    localparam logic [3:0] CC_C      = 4'h3;
    localparam logic [3:0] CC_NC     = 4'h4;
    localparam logic [3:0] CC_P      = 4'h5;
    localparam logic [3:0] CC_NP     = 4'h6;
    localparam logic [3:0] CC_O      = 4'h7;
    localparam logic [3:0] CC_NO     = 4'h8;
    localparam logic [3:0] CC_CZ     = 4'h9;
    localparam logic [3:0] CC_NCNZ   = 4'hA;
    localparam logic [3:0] CC_PNZ    = 4'hB;

    logic [3:0]       shadow;
    logic [3:0]       flags_next;
    logic [3:0]       shadow_next;
    logic [3:0]       eff_flags;
    logic             cond_true;
    logic             accept;
    logic             take;
    logic [CNT_W-1:0] cnt_next;

    // Handshake: blocked in reset, while flags are pending upstream, and
    // for the dead cycle in which a taken branch's flush propagates.
    assign br_ready = ~rst & ~flag_busy & ~redirect_valid;

    // Next-state for flag and shadow registers.
    // restore beats flag_we; save always captures the pre-edge flags,
    // so save+restore together swaps the two registers.
    always_comb begin
        flags_next  = flags;
        shadow_next = shadow;
        if (restore) begin
            flags_next = shadow;
        end else if (flag_we) begin
            flags_next = flag_in;
        end
        if (save) begin
            shadow_next = flags;
        end
    end

    // Flags a branch accepted this cycle is evaluated against: the same
    // value the flag register is about to take (bypass of the write).
    always_comb begin
        eff_flags = flags;
        if (restore) begin
            eff_flags = shadow;
        end else if (flag_we) begin
            eff_flags = flag_in;
        end
    end

    // Condition decode
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            CC_ALWAYS: cond_true = 1'b1;
            CC_Z:      cond_true = eff_flags[FLG_Z];
            CC_NZ:     cond_true = ~eff_flags[FLG_Z];
            CC_C:      cond_true = eff_flags[FLG_C];
            CC_NC:     cond_true = ~eff_flags[FLG_C];
            CC_P:      cond_true = eff_flags[FLG_P];
            CC_NP:     cond_true = ~eff_flags[FLG_P];
            CC_O:      cond_true = eff_flags[FLG_O];
            CC_NO:     cond_true = ~eff_flags[FLG_O];
            CC_CZ:     cond_true = eff_flags[FLG_C] | eff_flags[FLG_Z];
            CC_NCNZ:   cond_true = ~eff_flags[FLG_C] & ~eff_flags[FLG_Z];
            CC_PNZ:    cond_true = eff_flags[FLG_P] & ~eff_flags[FLG_Z];
            default:   cond_true = 1'b0;
        endcase
    end

    // Acceptance and taken-branch counter
    always_comb begin
        accept   = br_valid & br_ready;
        take     = accept & cond_true;
        cnt_next = taken_cnt;
        if (take && (taken_cnt != {CNT_W{1'b1}})) begin
            cnt_next = taken_cnt + CNT_W'(1);
        end
    end

    // State registers; reset also discards any redirect being formed.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags          <= 4'b0000;
            shadow         <= 4'b0000;
            cin_out        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            taken_cnt      <= '0;
        end else begin
            flags          <= flags_next;
            shadow         <= shadow_next;
            cin_out        <= flags_next[FLG_C];
            redirect_valid <= take;
            taken_cnt      <= cnt_next;
            if (take) begin
                redirect_pc <= br_target;
            end
        end
    end

endmodule

// File: doc/alu_flag_branch_unit.md
Name: alu_flag_branch_unit

Overview:
- Sits at the consuming end of the ALU flag interface.
- The ALU only drives its 4-bit flag vector {OddParity, Positive, Cout, Zero} combinationally and holds nothing.
- This block registers those flags, feeds carry back to the ALU carry input, and resolves conditional branches against the held flags. It issues a one-cycle redirect/flush to fetch.
- It also provides a single-level shadow copy of the flags for interrupt entry and exit.

Parameters:
- PC_W, 16, width of branch target and redirect PC.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flag_in  input  4  ALU flags {OddParity, Positive, Cout, Zero}, bit 3 down to bit 0.
- flag_we  input  1  write flag_in into the flag register this cycle.
- flag_busy  input  1  a flag-writing ALU op is in flight upstream of EX; branch must wait.
- save  input  1  copy flags into the shadow register (interrupt entry).
- restore  input  1  load flags from the shadow register (interrupt return).
- br_valid  input  1  branch request present.
- br_cond  input  4  condition code.
- br_target  input  PC_W  target PC.
- br_ready  output  1  branch request can be accepted this cycle.
- redirect_valid  output  1  one-cycle pulse: branch taken, flush younger stages.
- redirect_pc  output  PC_W  target of the taken branch; valid while redirect_valid is high.
- flags  output  4  current registered flags.
- cin_out  output  1  registered carry flag (flags[1]) driven to the ALU carry input.
- taken_cnt  output  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (rst high at clock edge):
  - flags = 4'b0000, shadow = 4'b0000.
  - redirect_valid = 0, redirect_pc = 0, taken_cnt = 0.
  - cin_out = 0, br_ready = 0 during the reset cycle.
  - Reset asserted mid-branch discards the pending redirect.
- Flag register next-state priority: restore > flag_we > hold.
  - restore loads shadow.
  - flag_we loads flag_in.
  - restore and flag_we in the same cycle: restore wins and flag_in is dropped.
- Shadow register:
  - save loads the pre-edge flags value, i.e. not the value being written that same cycle.
  - save and restore in the same cycle: flags take the old shadow, and shadow takes the old flags (swap).
- cin_out = flags[1]. It is registered, with no combinational path from flag_in.
- br_ready = ~rst & ~flag_busy & ~redirect_valid. This gives one dead cycle after every taken branch while the flush propagates.
- Acceptance: br_valid & br_ready at edge N.
  - Condition evaluated on effective flags: flag_in if flag_we is high in cycle N (bypass), otherwise flags. restore overrides the bypass and evaluates on shadow.
  - If the condition is true: redirect_valid = 1 and redirect_pc = br_target in cycle N+1 (latency 1). redirect_valid drops at N+2 unconditionally.
  - If the condition is false: no output change.
  - A request with br_valid high and br_ready low is neither evaluated nor counted; the requester holds it.
- Condition codes (Z = bit0, C = bit1, P = bit2 positive, O = bit3 odd parity):
  - 0 always; 1 Z; 2 ~Z; 3 C; 4 ~C; 5 P; 6 ~P; 7 O.
  - 8 ~O; 9 C|Z; A ~C&~Z; B P&~Z (strictly positive).
  - C..F never (reserved, treated as not taken).
- taken_cnt: increments on each redirect_valid assertion and saturates at all-ones (no wrap).
- redirect_pc holds its last value when redirect_valid is low.

Test Plan:
- Reset then idle: rst high 2 cycles -> flags=0, cin_out=0, redirect_valid=0, taken_cnt=0, br_ready=0 while in reset, br_ready=1 after.
- Bypass: flag_we=1, flag_in=4'b0001, br_valid=1, br_cond=1, br_target=16'h1234 in the same cycle -> next cycle redirect_valid=1, redirect_pc=16'h1234, flags=4'b0001; following cycle redirect_valid=0 and br_ready back to 1.
- Not taken / reserved: flags=4'b0010, br_cond=4 (~C) -> no redirect; br_cond=4'hE -> no redirect; taken_cnt unchanged.
- Stall: flag_busy=1 with br_valid=1 for 3 cycles -> br_ready=0 and no redirect. flag_busy drops with flags=4'b0110 and br_cond=B -> redirect one cycle after acceptance.
- Shadow: flags=4'b1010, pulse save, write flag_in=4'b0101, then restore with flag_we=1 and flag_in=4'b1111 -> flags=4'b1010 and cin_out=1. Then save and restore together with flags=4'b0101 and shadow=4'b1010 -> flags=4'b1010, shadow=4'b0101.
- Saturation: CNT_W=4, drive 17 taken branches (br_cond=0) -> taken_cnt stops at 4'hF. Each back-to-back request sees br_ready=0 in the cycle after a redirect.
